// File: rtl/voting_machine_n.sv
// ---------------------------------------------------------------------------
// voting_machine_n
//
// Parametrised front-panel voting machine. Each candidate has one debounced
// button. A vote is counted once a single button has been sampled high for
// HOLD_CYCLES consecutive clocks. A press involving more than one button is
// rejected and flagged. Per-candidate counters and the running total
// saturate. Result mode shows the count of a selected candidate. The leader
// index and tie flag are maintained in both modes.
//
// Ports:
//   clock      in   rising-edge system clock
//   reset      in   asynchronous, active-high; clears all state
//   mode       in   0 = voting, 1 = result display
//   buttons    in   [NUM_CAND] one bit per candidate (bit i = candidate i)
//   led        out  [COUNT_W] displayed count (0 while voting)
//   vote_valid out  one-cycle pulse after a vote is registered
//   multi_err  out  one-cycle pulse when a multi-button press is rejected
//   winner     out  [clog2(NUM_CAND)] lowest index holding the max count
//   tie        out  nonzero maximum shared by two or more candidates
//   total      out  [COUNT_W+clog2(NUM_CAND)] saturating sum of all votes
// ---------------------------------------------------------------------------
module voting_machine_n #(
    parameter int NUM_CAND    = 4,
    parameter int COUNT_W     = 8,
    parameter int HOLD_CYCLES = 100,
    localparam int IDX_W      = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1,
    localparam int TOT_W      = COUNT_W + IDX_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] buttons,
    output logic [COUNT_W-1:0]  led,
    output logic                vote_valid,
    output logic                multi_err,
    output logic [IDX_W-1:0]    winner,
    output logic                tie,
    output logic [TOT_W-1:0]    total
);

    localparam int HC_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [HC_W-1:0]    hold_q, hold_d;
    logic [COUNT_W-1:0] count_q [NUM_CAND];
    logic [COUNT_W-1:0] count_d [NUM_CAND];
    logic [TOT_W-1:0]   total_q, total_d;
    logic [COUNT_W-1:0] led_q, led_d;
    logic               vv_q, me_q;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic               tie_q, tie_d;

    logic               any_hi, multi_hi;
    logic [IDX_W-1:0]   low_idx;
    logic               latched_hi, others_hi;
    logic               vote, err;

    function automatic logic [COUNT_W-1:0] sat_inc_count(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    function automatic logic [TOT_W-1:0] sat_inc_total(input logic [TOT_W-1:0] v);
        return (&v) ? v : v + TOT_W'(1);
    endfunction

    // Button decode. Scanning from the top down leaves the lowest-index
    // high button in low_idx, which both the FSM and the display use.
    always_comb begin
        any_hi   = 1'b0;
        multi_hi = 1'b0;
        low_idx  = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (buttons[i]) begin
                if (any_hi) multi_hi = 1'b1;
                any_hi  = 1'b1;
                low_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        logic [NUM_CAND-1:0] sel_mask;
        sel_mask           = '0;
        sel_mask[idx_q]    = 1'b1;
        latched_hi         = |(buttons & sel_mask);
        others_hi          = |(buttons & ~sel_mask);
    end

    // Vote FSM next-state. hold_q counts consecutive samples of the latched
    // button; the vote fires on the edge that takes the sample count to
    // HOLD_CYCLES.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        vote    = 1'b0;
        err     = 1'b0;
        if (mode) begin
            // Result mode abandons any press in progress.
            state_d = IDLE;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (multi_hi) begin
                        err     = 1'b1;
                        state_d = WAIT_REL;
                    end else if (any_hi) begin
                        idx_d   = low_idx;
                        hold_d  = HC_W'(1);
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!latched_hi) begin
                        // Released early: no vote, and no error even if a
                        // different button has taken its place.
                        state_d = any_hi ? WAIT_REL : IDLE;
                    end else if (others_hi) begin
                        err     = 1'b1;
                        state_d = WAIT_REL;
                    end else if (hold_q == HC_W'(HOLD_CYCLES - 1)) begin
                        vote    = 1'b1;
                        state_d = WAIT_REL;
                    end else begin
                        hold_d = hold_q + HC_W'(1);
                    end
                end
                WAIT_REL: begin
                    if (!any_hi) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        total_d = total_q;
        if (vote) begin
            count_d[idx_q] = sat_inc_count(count_q[idx_q]);
            total_d        = sat_inc_total(total_q);
        end
    end

    // Display: zero while voting; in result mode follow the lowest pressed
    // button and hold the last value once all buttons are released.
    always_comb begin
        led_d = led_q;
        if (!mode) begin
            led_d = '0;
        end else if (any_hi) begin
            led_d = count_q[low_idx];
        end
    end

    // Leader scan over the registered counts. Strict '>' keeps the lowest
    // index on equal counts; a later equal nonzero count marks a tie.
    always_comb begin
        logic [COUNT_W-1:0] max_v;
        max_v    = '0;
        winner_d = '0;
        tie_d    = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (count_q[i] > max_v) begin
                max_v    = count_q[i];
                winner_d = IDX_W'(i);
                tie_d    = 1'b0;
            end else if ((count_q[i] == max_v) && (max_v != '0)) begin
                tie_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            hold_q   <= '0;
            total_q  <= '0;
            led_q    <= '0;
            vv_q     <= 1'b0;
            me_q     <= 1'b0;
            winner_q <= '0;
            tie_q    <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) count_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            total_q  <= total_d;
            led_q    <= led_d;
            vv_q     <= vote;
            me_q     <= err;
            winner_q <= winner_d;
            tie_q    <= tie_d;
            for (int i = 0; i < NUM_CAND; i++) count_q[i] <= count_d[i];
        end
    end

    assign led        = led_q;
    assign vote_valid = vv_q;
    assign multi_err  = me_q;
    assign winner     = winner_q;
    assign tie        = tie_q;
    assign total      = total_q;

endmodule

// File: tb/tb_voting_machine_n.sv
module tb_voting_machine_n;

    localparam int HC = 100;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    // Main instance: default widths.
    logic       reset, mode;
    logic [3:0] buttons;
    logic [7:0] led;
    logic       vote_valid, multi_err, tie;
    logic [1:0] winner;
    logic [9:0] total;

    // Second instance: 2-bit counters for saturation.
    logic       reset2, mode2;
    logic [3:0] buttons2;
    logic [1:0] led2;
    logic       vote_valid2, multi_err2, tie2;
    logic [1:0] winner2;
    logic [3:0] total2;

    voting_machine_n #(.NUM_CAND(4), .COUNT_W(8), .HOLD_CYCLES(HC)) dut (
        .clock(clock), .reset(reset), .mode(mode), .buttons(buttons),
        .led(led), .vote_valid(vote_valid), .multi_err(multi_err),
        .winner(winner), .tie(tie), .total(total)
    );

    voting_machine_n #(.NUM_CAND(4), .COUNT_W(2), .HOLD_CYCLES(HC)) dut2 (
        .clock(clock), .reset(reset2), .mode(mode2), .buttons(buttons2),
        .led(led2), .vote_valid(vote_valid2), .multi_err(multi_err2),
        .winner(winner2), .tie(tie2), .total(total2)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vv_cnt   = 0;
    int me_cnt   = 0;
    int vv_cyc   = 0;
    int vv2_cnt  = 0;
    int exp_q[$];
    int exp2_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: each expected vote pushes the total it should produce.
    always @(negedge clock) begin
        if (vote_valid) begin
            vv_cnt = vv_cnt + 1;
            vv_cyc = cyc;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_vote: vote_valid=1 total=%0d, no vote expected", total);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (total !== 10'(e)) begin
                    failures = failures + 1;
                    $display("FAIL vote_total: got %0d expected %0d", total, e);
                end
            end
        end
        if (multi_err) me_cnt = me_cnt + 1;
        if (vote_valid || multi_err) begin
            checks = checks + 1;
            if (vote_valid && multi_err) begin
                failures = failures + 1;
                $display("FAIL exclusive_pulses: vote_valid=%b multi_err=%b, required not both", vote_valid, multi_err);
            end
        end
    end

    always @(negedge clock) begin
        if (vote_valid2) begin
            vv2_cnt = vv2_cnt + 1;
            checks  = checks + 1;
            if (exp2_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_vote2: vote_valid2=1 total2=%0d", total2);
            end else begin
                int e;
                e = exp2_q.pop_front();
                if (total2 !== 4'(e)) begin
                    failures = failures + 1;
                    $display("FAIL vote_total2: got %0d expected %0d", total2, e);
                end
            end
            if (multi_err2) begin
                failures = failures + 1;
                $display("FAIL exclusive_pulses2: multi_err2=1 with vote_valid2=1, required 0");
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] m, input int n);
        buttons = m;
        step(n);
        buttons = '0;
        step(3);
    endtask

    task automatic press2(input logic [3:0] m, input int n);
        buttons2 = m;
        step(n);
        buttons2 = '0;
        step(3);
    endtask

    task automatic peek_count(input int idx, output logic [7:0] v);
        mode    = 1'b1;
        buttons = 4'(1 << idx);
        step(1);
        v       = led;
        buttons = '0;
        mode    = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        reset = 1'b1; reset2 = 1'b1;
        mode = 1'b0; mode2 = 1'b0;
        buttons = '0; buttons2 = '0;
        step(2);
        checks = checks + 1;
        if ({led, vote_valid, multi_err, winner, tie, total} !== '0) begin
            failures = failures + 1;
            $display("FAIL reset_outputs: led=%0d vv=%b me=%b win=%0d tie=%b total=%0d, required all 0",
                     led, vote_valid, multi_err, winner, tie, total);
        end
        checks = checks + 1;
        if ({led2, vote_valid2, multi_err2, winner2, tie2, total2} !== '0) begin
            failures = failures + 1;
            $display("FAIL reset_outputs2: led2=%0d total2=%0d win2=%0d, required all 0", led2, total2, winner2);
        end
        reset = 1'b0; reset2 = 1'b0;
        step(2);
    endtask

    task automatic test_single_vote();
        int c0, v0;
        logic [7:0] v;
        c0 = cyc; v0 = vv_cnt;
        exp_q.push_back(1);
        press(4'b0010, 110);
        checks = checks + 1;
        if (vv_cnt - v0 !== 1) begin
            failures = failures + 1;
            $display("FAIL single_vote_pulses: got %0d expected 1", vv_cnt - v0);
        end
        checks = checks + 1;
        if (vv_cyc - c0 !== HC) begin
            failures = failures + 1;
            $display("FAIL vote_latency: pulse at hold cycle %0d expected %0d", vv_cyc - c0, HC);
        end
        checks = checks + 1;
        if (winner !== 2'd1 || tie !== 1'b0 || total !== 10'd1 || led !== 8'd0) begin
            failures = failures + 1;
            $display("FAIL single_vote_state: win=%0d tie=%b total=%0d led=%0d expected 1 0 1 0",
                     winner, tie, total, led);
        end
        peek_count(1, v);
        checks = checks + 1;
        if (v !== 8'd1) begin
            failures = failures + 1;
            $display("FAIL count1_after_vote: got %0d expected 1", v);
        end
    endtask

    task automatic test_short_press();
        int v0;
        logic [7:0] v;
        v0 = vv_cnt;
        press(4'b0001, 60);
        checks = checks + 1;
        if (vv_cnt !== v0 || total !== 10'd1) begin
            failures = failures + 1;
            $display("FAIL short_press: pulses=%0d total=%0d expected 0 and 1", vv_cnt - v0, total);
        end
        peek_count(0, v);
        checks = checks + 1;
        if (v !== 8'd0) begin
            failures = failures + 1;
            $display("FAIL count0_short: got %0d expected 0", v);
        end
    endtask

    task automatic test_long_hold();
        int v0;
        logic [7:0] v;
        v0 = vv_cnt;
        exp_q.push_back(2);
        press(4'b0100, 300);
        checks = checks + 1;
        if (vv_cnt - v0 !== 1) begin
            failures = failures + 1;
            $display("FAIL long_hold_pulses: got %0d expected 1", vv_cnt - v0);
        end
        exp_q.push_back(3);
        press(4'b0100, 110);
        peek_count(2, v);
        checks = checks + 1;
        if (v !== 8'd2) begin
            failures = failures + 1;
            $display("FAIL count2: got %0d expected 2", v);
        end
        checks = checks + 1;
        if (winner !== 2'd2 || tie !== 1'b0 || total !== 10'd3) begin
            failures = failures + 1;
            $display("FAIL leader_c2: win=%0d tie=%b total=%0d expected 2 0 3", winner, tie, total);
        end
    endtask

    task automatic test_multi();
        int v0, m0;
        v0 = vv_cnt; m0 = me_cnt;
        press(4'b1001, 20);
        checks = checks + 1;
        if (me_cnt - m0 !== 1 || vv_cnt !== v0) begin
            failures = failures + 1;
            $display("FAIL multi_idle: errs=%0d votes=%0d expected 1 0", me_cnt - m0, vv_cnt - v0);
        end
        buttons = 4'b0001;
        step(50);
        buttons = 4'b1001;
        step(100);
        buttons = '0;
        step(3);
        checks = checks + 1;
        if (me_cnt - m0 !== 2 || vv_cnt !== v0 || total !== 10'd3) begin
            failures = failures + 1;
            $display("FAIL multi_hold: errs=%0d votes=%0d total=%0d expected 2 0 3",
                     me_cnt - m0, vv_cnt - v0, total);
        end
        exp_q.push_back(4);
        press(4'b1000, 110);
        checks = checks + 1;
        if (vv_cnt - v0 !== 1 || total !== 10'd4) begin
            failures = failures + 1;
            $display("FAIL after_multi: votes=%0d total=%0d expected 1 4", vv_cnt - v0, total);
        end
    endtask

    task automatic test_mode_discard();
        int v0;
        v0 = vv_cnt;
        buttons = 4'b0001;
        step(50);
        mode = 1'b1;
        step(5);
        mode = 1'b0;
        step(60);
        buttons = '0;
        step(3);
        checks = checks + 1;
        if (vv_cnt !== v0 || total !== 10'd4) begin
            failures = failures + 1;
            $display("FAIL mode_discard: votes=%0d total=%0d expected 0 4", vv_cnt - v0, total);
        end
    endtask

    task automatic test_tie_display();
        exp_q.push_back(5);
        press(4'b0010, 110);
        exp_q.push_back(6);
        press(4'b1000, 110);
        checks = checks + 1;
        if (tie !== 1'b1 || winner !== 2'd1 || total !== 10'd6) begin
            failures = failures + 1;
            $display("FAIL tie_state: tie=%b win=%0d total=%0d expected 1 1 6", tie, winner, total);
        end
        mode = 1'b1;
        buttons = 4'b1000;
        step(1);
        checks = checks + 1;
        if (led !== 8'h02) begin
            failures = failures + 1;
            $display("FAIL led_show: got %0d expected 2", led);
        end
        buttons = '0;
        step(3);
        checks = checks + 1;
        if (led !== 8'h02) begin
            failures = failures + 1;
            $display("FAIL led_hold: got %0d expected 2", led);
        end
        mode = 1'b0;
        step(1);
        checks = checks + 1;
        if (led !== 8'h00) begin
            failures = failures + 1;
            $display("FAIL led_clear: got %0d expected 0", led);
        end
    endtask

    task automatic test_saturate_reset();
        int v0;
        v0 = vv2_cnt;
        for (int k = 1; k <= 4; k++) begin
            exp2_q.push_back(k);
            press2(4'b0001, 110);
        end
        checks = checks + 1;
        if (vv2_cnt - v0 !== 4 || total2 !== 4'd4) begin
            failures = failures + 1;
            $display("FAIL sat_votes: pulses=%0d total2=%0d expected 4 4", vv2_cnt - v0, total2);
        end
        mode2 = 1'b1;
        buttons2 = 4'b0001;
        step(1);
        checks = checks + 1;
        if (led2 !== 2'd3 || winner2 !== 2'd0 || tie2 !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL sat_count: led2=%0d win2=%0d tie2=%b expected 3 0 0", led2, winner2, tie2);
        end
        buttons2 = '0;
        mode2 = 1'b0;
        step(1);
        buttons2 = 4'b0001;
        step(50);
        reset2 = 1'b1;
        #1;
        checks = checks + 1;
        if ({led2, vote_valid2, multi_err2, winner2, tie2, total2} !== '0) begin
            failures = failures + 1;
            $display("FAIL async_reset: led2=%0d total2=%0d win2=%0d, required all 0", led2, total2, winner2);
        end
        step(2);
        reset2 = 1'b0;
        v0 = vv2_cnt;
        exp2_q.push_back(1);
        step(110);
        buttons2 = '0;
        step(3);
        checks = checks + 1;
        if (vv2_cnt - v0 !== 1 || total2 !== 4'd1) begin
            failures = failures + 1;
            $display("FAIL press_after_reset: pulses=%0d total2=%0d expected 1 1", vv2_cnt - v0, total2);
        end
    endtask

    initial begin
        test_reset();
        test_single_vote();
        test_short_press();
        test_long_hold();
        test_multi();
        test_mode_discard();
        test_tie_display();
        test_saturate_reset();
        step(3);
        checks = checks + 1;
        if (exp_q.size() != 0 || exp2_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL missing_votes: pending=%0d/%0d expected 0/0", exp_q.size(), exp2_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voting_machine_n.md
Name: voting_machine_n

Overview:
- Parametrised successor to the four-button voting machine.
- Supports NUM_CAND candidates with a configurable hold-to-vote threshold and saturating per-candidate counters.
- Enforces one vote per press; any press involving more than one button is rejected and flagged.
- In result mode, shows the selected candidate's count plus a continuously maintained leader index, tie flag and vote total.
- Sits between debounced front-panel buttons and the LED/display driver.

Parameters:
- NUM_CAND, 4, number of candidates/buttons (>=2).
- COUNT_W, 8, width of each per-candidate vote counter and of led.
- HOLD_CYCLES, 100, consecutive clock cycles a single button must be sampled high for a vote to count (>=2).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- mode  input  1  0 = voting, 1 = result display.
- buttons  input  NUM_CAND  one bit per candidate, synchronous to clock; bit i = candidate i.
- led  output  COUNT_W  displayed vote count.
- vote_valid  output  1  one-cycle pulse when a vote is registered.
- multi_err  output  1  one-cycle pulse when a press is rejected for multiple buttons.
- winner  output  clog2(NUM_CAND)  index of the candidate with the highest count.
- tie  output  1  high when two or more candidates share a nonzero maximum.
- total  output  COUNT_W+clog2(NUM_CAND)  sum of all registered votes, saturating.

Behaviour:
- Reset (asynchronous): all counts, led, vote_valid, multi_err, winner, tie and total = 0; FSM = IDLE; hold counter = 0.
- Vote FSM (active only when mode=0), states IDLE, HOLD, WAIT_REL:
  - IDLE, exactly one button high: latch its index, hold_cnt := 1, go to HOLD.
  - IDLE, two or more buttons high: pulse multi_err, go to WAIT_REL.
  - IDLE, no button high: stay in IDLE.
  - HOLD, only the latched button high: hold_cnt += 1. On the edge where the button has been sampled high HOLD_CYCLES consecutive times, register the vote and go to WAIT_REL.
  - HOLD, latched button dropped before threshold: no vote; go to IDLE if all buttons are low, else WAIT_REL.
  - HOLD, any other button high: no vote; pulse multi_err; go to WAIT_REL.
  - WAIT_REL: stay until buttons == 0, then IDLE. Holding a button indefinitely yields exactly one vote.
- Registering a vote:
  - count[idx] += 1, saturating at 2^COUNT_W-1.
  - total += 1, saturating at its own maximum.
  - vote_valid is high for the one cycle after the counting edge; it pulses even when the count is saturated.
- mode=1 while the FSM is in HOLD or WAIT_REL: FSM goes to IDLE on the next edge and the pending press is discarded. No votes are counted while mode=1.
- led:
  - mode=0: led = 0.
  - mode=1: led is registered with 1-cycle latency. When any button is high, it shows the count of the lowest-index high button; when no button is high, it holds its last value.
  - Switching mode from 1 to 0 forces led to 0 on the next edge.
- winner and tie:
  - Registered from the current counts every cycle, with 1-cycle latency after a count update. They are valid in both modes.
  - winner = lowest index among the candidates holding the maximum count; winner = 0 when all counts are 0.
  - tie = 1 only if the maximum is greater than 0 and held by two or more candidates.
- multi_err and vote_valid never assert in the same cycle.
- Reset asserted mid-hold clears everything immediately; buttons still high at reset release are treated as a fresh press from IDLE.

Test Plan:
- Reset, then button[1] high for 110 cycles, then release -> exactly one vote_valid pulse, near cycle 100 of the hold; count[1]=1, total=1, winner=1, tie=0.
- button[0] high for 60 cycles, then release -> no vote_valid; all counts unchanged.
- button[2] high for 300 cycles -> exactly one vote; a second 110-cycle press after release -> count[2]=2.
- button[0] and button[3] high together -> multi_err pulse, no vote; button[3] added at cycle 50 of a button[0] hold -> multi_err, no vote; after release, a valid press is accepted.
- Votes A=2, B=2 on candidates 1 and 3 -> tie=1, winner=1. Then mode=1, button[3] high -> led=8'h02 one cycle later; release -> led holds 8'h02. Then mode=0 -> led=0.
- COUNT_W=2: four valid votes for candidate 0 -> count[0] stays 3, four vote_valid pulses, total=4. Reset during the fifth hold -> all outputs 0 immediately.
